cpu: RTL and testbench

- Single-cycle 32-bit MIPS-subset processor with internal instruction ROM, 32x32 register file and data RAM.
- Top-level compute block of the course-lab system; driven only by clock and reset.
- Exposes the current PC and the current ALU result for observation.

---
 rtl/cpu.sv | 199 +++++++++++++++++++
 tb/tb_cpu.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu.sv
// Single-cycle MIPS-subset core with built-in program ROM, 32x32 register file and data RAM.
// Optional feature macro: CPU_BNE_EN (adds bne; without it op 000101 behaves as a NOP).
module cpu #(
    parameter int IMEM_WORDS = 32,
    parameter int DMEM_WORDS = 32
) (
    input  logic        Clock,
    input  logic        Reset,
    output logic [31:0] addr,
    output logic [31:0] result
);

    localparam int IAW = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;
    localparam int DAW = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
`ifdef CPU_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'b000101;
`endif
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    // Fixed program image; unlisted words are zero, which decodes as a NOP.
    function automatic logic [31:0] rom_word(input logic [IAW-1:0] idx);
        logic [31:0] w;
        case (idx)
            IAW'(0):  w = 32'h2001_0005;  // addi $1,$0,5
            IAW'(1):  w = 32'h2002_0003;  // addi $2,$0,3
            IAW'(2):  w = 32'h0022_1820;  // add  $3,$1,$2
            IAW'(3):  w = 32'h0022_2022;  // sub  $4,$1,$2
            IAW'(4):  w = 32'h0022_2824;  // and  $5,$1,$2
            IAW'(5):  w = 32'h0022_3025;  // or   $6,$1,$2
            IAW'(6):  w = 32'h0041_382A;  // slt  $7,$2,$1
            IAW'(7):  w = 32'hAC03_0000;  // sw   $3,0($0)
            IAW'(8):  w = 32'h8C08_0000;  // lw   $8,0($0)
            IAW'(9):  w = 32'h1103_0001;  // beq  $8,$3,+1
            IAW'(10): w = 32'h2009_0001;  // addi $9,$0,1
            IAW'(11): w = 32'h0800_000B;  // j    11
            default:  w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    logic [31:0] pc_r;
    logic [31:0] rf_r   [32];
    logic [31:0] dmem_r [DMEM_WORDS];

    logic [31:0]    instr_s;
    logic [5:0]     op_s;
    logic [5:0]     funct_s;
    logic [4:0]     rs_s;
    logic [4:0]     rt_s;
    logic [4:0]     rd_s;
    logic [31:0]    sext_s;
    logic [31:0]    rs_val_s;
    logic [31:0]    rt_val_s;
    logic [31:0]    ea_s;
    logic [DAW-1:0] dmem_idx_s;
    logic [31:0]    pc4_s;
    logic [31:0]    branch_tgt_s;
    logic [31:0]    diff_s;

    logic [31:0] alu_s;
    logic        reg_we_s;
    logic [4:0]  wr_reg_s;
    logic [31:0] wr_data_s;
    logic        mem_we_s;
    logic [31:0] next_pc_s;

    assign instr_s      = rom_word(pc_r[IAW+1:2]);
    assign op_s         = instr_s[31:26];
    assign rs_s         = instr_s[25:21];
    assign rt_s         = instr_s[20:16];
    assign rd_s         = instr_s[15:11];
    assign funct_s      = instr_s[5:0];
    assign sext_s       = {{16{instr_s[15]}}, instr_s[15:0]};
    // $0 is never written, but forcing zero here keeps reads safe regardless of storage.
    assign rs_val_s     = (rs_s == 5'd0) ? 32'd0 : rf_r[rs_s];
    assign rt_val_s     = (rt_s == 5'd0) ? 32'd0 : rf_r[rt_s];
    assign ea_s         = rs_val_s + sext_s;
    assign dmem_idx_s   = ea_s[DAW+1:2];
    assign pc4_s        = pc_r + 32'd4;
    assign branch_tgt_s = pc4_s + {sext_s[29:0], 2'b00};
    assign diff_s       = rs_val_s - rt_val_s;

    // Decode, ALU, writeback selection and next-PC selection.
    always_comb begin
        alu_s     = 32'd0;
        reg_we_s  = 1'b0;
        wr_reg_s  = 5'd0;
        wr_data_s = 32'd0;
        mem_we_s  = 1'b0;
        next_pc_s = pc4_s;
        case (op_s)
            OP_RTYPE: begin
                wr_reg_s = rd_s;
                case (funct_s)
                    FN_ADD: begin alu_s = rs_val_s + rt_val_s; reg_we_s = 1'b1; end
                    FN_SUB: begin alu_s = diff_s;              reg_we_s = 1'b1; end
                    FN_AND: begin alu_s = rs_val_s & rt_val_s; reg_we_s = 1'b1; end
                    FN_OR:  begin alu_s = rs_val_s | rt_val_s; reg_we_s = 1'b1; end
                    FN_SLT: begin
                        alu_s    = ($signed(rs_val_s) < $signed(rt_val_s)) ? 32'd1 : 32'd0;
                        reg_we_s = 1'b1;
                    end
                    default: begin
                        alu_s    = 32'd0;
                        reg_we_s = 1'b0;
                    end
                endcase
                wr_data_s = alu_s;
            end
            OP_ADDI: begin
                alu_s     = ea_s;
                reg_we_s  = 1'b1;
                wr_reg_s  = rt_s;
                wr_data_s = ea_s;
            end
            OP_LW: begin
                alu_s     = ea_s;
                reg_we_s  = 1'b1;
                wr_reg_s  = rt_s;
                wr_data_s = dmem_r[dmem_idx_s];
            end
            OP_SW: begin
                alu_s    = ea_s;
                mem_we_s = 1'b1;
            end
            OP_BEQ: begin
                alu_s = diff_s;
                if (diff_s == 32'd0) begin
                    next_pc_s = branch_tgt_s;
                end else begin
                    next_pc_s = pc4_s;
                end
            end
`ifdef CPU_BNE_EN
            OP_BNE: begin
                alu_s = diff_s;
                if (diff_s != 32'd0) begin
                    next_pc_s = branch_tgt_s;
                end else begin
                    next_pc_s = pc4_s;
                end
            end
`endif
            OP_J: begin
                next_pc_s = {pc4_s[31:28], instr_s[25:0], 2'b00};
            end
            default: begin
                next_pc_s = pc4_s;
            end
        endcase
    end

    // Program counter.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            pc_r <= 32'd0;
        end else begin
            pc_r <= next_pc_s;
        end
    end

    // Register file write port; writes to $0 are dropped.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < 32; i++) begin
                rf_r[i] <= 32'd0;
            end
        end else if (reg_we_s && (wr_reg_s != 5'd0)) begin
            rf_r[wr_reg_s] <= wr_data_s;
        end
    end

    // Data RAM write port.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < DMEM_WORDS; i++) begin
                dmem_r[i] <= 32'd0;
            end
        end else if (mem_we_s) begin
            dmem_r[dmem_idx_s] <= rt_val_s;
        end
    end

    assign addr   = pc_r;
    assign result = alu_s;

endmodule

// File: tb/tb_cpu.sv
// Self-checking bench for cpu: an instruction-level interpreter of the program is compared every cycle,
// with randomized asynchronous reset pulses and literal expectations from the reference program trace.
module tb_cpu;

    logic        Clock;
    logic        Reset;
    logic [31:0] addr;
    logic [31:0] result;

    cpu dut (
        .Clock  (Clock),
        .Reset  (Reset),
        .addr   (addr),
        .result (result)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;
    bit seen40   = 1'b0;

    // Interpreter state
    logic [31:0] mrom  [32];
    logic [31:0] mregs [32];
    logic [31:0] mram  [32];
    logic [31:0] mpc;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
        return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'b00000, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] enc_j(input int target);
        return {6'b000010, 26'(target)};
    endfunction

    task automatic model_clear();
        mpc = 32'd0;
        for (int i = 0; i < 32; i++) begin
            mregs[i] = 32'd0;
            mram[i]  = 32'd0;
        end
    endtask

    // Evaluate the instruction at mpc; if commit, apply its architectural effects.
    task automatic model_exec(input bit commit, output logic [31:0] res);
        logic [31:0] ins, a, b, se, pc4, npc, wval;
        logic [5:0]  op, fn;
        int          rs, rt, rd, wreg;
        bit          we;
        ins  = mrom[mpc[6:2]];
        op   = ins[31:26];
        fn   = ins[5:0];
        rs   = int'(ins[25:21]);
        rt   = int'(ins[20:16]);
        rd   = int'(ins[15:11]);
        a    = mregs[rs];
        b    = mregs[rt];
        se   = {{16{ins[15]}}, ins[15:0]};
        pc4  = mpc + 32'd4;
        npc  = pc4;
        res  = 32'd0;
        we   = 1'b0;
        wreg = 0;
        wval = 32'd0;
        if (op == 6'd0) begin
            we   = 1'b1;
            wreg = rd;
            if (fn == 6'h20)      res = a + b;
            else if (fn == 6'h22) res = a - b;
            else if (fn == 6'h24) res = a & b;
            else if (fn == 6'h25) res = a | b;
            else if (fn == 6'h2A) res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            else we = 1'b0;
            wval = res;
        end else if (op == 6'h08) begin
            res = a + se; we = 1'b1; wreg = rt; wval = res;
        end else if (op == 6'h23) begin
            res = a + se; we = 1'b1; wreg = rt; wval = mram[res[6:2]];
        end else if (op == 6'h2B) begin
            res = a + se;
            if (commit) mram[res[6:2]] = b;
        end else if (op == 6'h04) begin
            res = a - b;
            if (a == b) npc = pc4 + (se << 2);
`ifdef CPU_BNE_EN
        end else if (op == 6'h05) begin
            res = a - b;
            if (a != b) npc = pc4 + (se << 2);
`endif
        end else if (op == 6'h02) begin
            npc = {pc4[31:28], ins[25:0], 2'b00};
        end
        if (commit) begin
            if (we && wreg != 0) mregs[wreg] = wval;
            mpc = npc;
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mrom[i] = 32'd0;
        mrom[0]  = enc_i(6'h08, 0, 1, 5);
        mrom[1]  = enc_i(6'h08, 0, 2, 3);
        mrom[2]  = enc_r(1, 2, 3, 6'h20);
        mrom[3]  = enc_r(1, 2, 4, 6'h22);
        mrom[4]  = enc_r(1, 2, 5, 6'h24);
        mrom[5]  = enc_r(1, 2, 6, 6'h25);
        mrom[6]  = enc_r(2, 1, 7, 6'h2A);
        mrom[7]  = enc_i(6'h2B, 0, 3, 0);
        mrom[8]  = enc_i(6'h23, 0, 8, 0);
        mrom[9]  = enc_i(6'h04, 8, 3, 1);
        mrom[10] = enc_i(6'h08, 0, 9, 1);
        mrom[11] = enc_j(11);
        model_clear();
    end

    always @(negedge Reset) model_clear();

    always @(posedge Clock) begin
        logic [31:0] r;
        if (Reset === 1'b1) model_exec(1'b1, r);
    end

    // Per-cycle comparison against the interpreter.
    always @(negedge Clock) begin
        logic [31:0] r;
        int bad_reg, bad_ram;
        if (cmp_en) begin
            model_exec(1'b0, r);
            check32("addr", addr, mpc);
            check32("result", result, r);
            bad_reg = -1;
            bad_ram = -1;
            for (int i = 0; i < 32; i++) begin
                if (dut.rf_r[i] !== mregs[i]) bad_reg = i;
                if (dut.dmem_r[i] !== mram[i]) bad_ram = i;
            end
            n_checks += 2;
            if (bad_reg >= 0) begin
                n_errors++;
                $display("FAIL regfile: reg %0d got %h, expected %h", bad_reg, dut.rf_r[bad_reg], mregs[bad_reg]);
            end
            if (bad_ram >= 0) begin
                n_errors++;
                $display("FAIL dmem: word %0d got %h, expected %h", bad_ram, dut.dmem_r[bad_ram], mram[bad_ram]);
            end
            if (Reset === 1'b1 && addr == 32'd40) seen40 = 1'b1;
        end
    end

    task automatic check_all_zero(input string tag);
        logic [31:0] acc;
        acc = 32'd0;
        for (int i = 0; i < 32; i++) acc = acc | dut.rf_r[i] | dut.dmem_r[i];
        check32(tag, acc, 32'd0);
    endtask

    logic [31:0] exp_a [12] = '{32'd0, 32'd4, 32'd8, 32'd12, 32'd16, 32'd20,
                                32'd24, 32'd28, 32'd32, 32'd36, 32'd44, 32'd44};
    logic [31:0] exp_r [12] = '{32'd5, 32'd3, 32'd8, 32'd2, 32'd1, 32'd7,
                                32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};

    initial begin
        int hold;
        Reset = 1'b1;
        #1 Reset = 1'b0;
        #1 cmp_en = 1'b1;

        // Reset held across two edges
        repeat (2) begin
            @(posedge Clock);
            #1 check32("addr_in_reset", addr, 32'd0);
        end
        @(negedge Clock);
        #2 Reset = 1'b1;
        #1;
        check32("trace_addr_0", addr, exp_a[0]);
        check32("trace_res_0", result, exp_r[0]);
        for (int k = 1; k < 12; k++) begin
            @(negedge Clock);
            #1;
            check32($sformatf("trace_addr_%0d", k), addr, exp_a[k]);
            check32($sformatf("trace_res_%0d", k), result, exp_r[k]);
        end
        check32("reg1", dut.rf_r[1], 32'd5);
        check32("reg2", dut.rf_r[2], 32'd3);
        check32("reg3", dut.rf_r[3], 32'd8);
        check32("reg4", dut.rf_r[4], 32'd2);
        check32("reg5", dut.rf_r[5], 32'd1);
        check32("reg6", dut.rf_r[6], 32'd7);
        check32("reg7", dut.rf_r[7], 32'd1);
        check32("reg8", dut.rf_r[8], 32'd8);
        check32("reg9", dut.rf_r[9], 32'd0);
        check32("ram0", dut.dmem_r[0], 32'd8);

        // Asynchronous reset in the middle of a cycle at the self-loop
        @(negedge Clock);
        #2 Reset = 1'b0;
        #1;
        check32("async_addr", addr, 32'd0);
        check32("async_result", result, 32'd5);
        check_all_zero("async_state_zero");
        @(posedge Clock);
        @(negedge Clock);
        #2 Reset = 1'b1;

        // Random run lengths and random reset pulses
        for (int it = 0; it < 40; it++) begin
            repeat ($urandom_range(1, 20)) @(posedge Clock);
            @(negedge Clock);
            #($urandom_range(1, 3)) Reset = 1'b0;
            #1;
            check32("rand_async_addr", addr, 32'd0);
            check_all_zero("rand_async_zero");
            hold = $urandom_range(0, 3);
            repeat (hold) @(posedge Clock);
            @(negedge Clock);
            #($urandom_range(1, 4)) Reset = 1'b1;
        end
        repeat (20) @(posedge Clock);
        @(negedge Clock);
        #1;
        cmp_en = 1'b0;
        check32("never_at_40", {31'd0, seen40}, 32'd0);
        check32("final_addr", addr, 32'd44);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
